// File: rtl/accu_sum4.sv
// accu_sum4 - streaming group accumulator.
//
// Sums every NUM_ITEMS consecutive accepted samples and presents the group
// total on data_out together with a one-cycle valid_out pulse. Groups may run
// back-to-back with no dead cycles. Clearing valid_in pauses a group; it does
// not abort it.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   data_in    in   DATA_W  input sample, unsigned
//   valid_in   in   1       data_in is accepted on this rising edge
//   valid_out  out  1       one-cycle pulse, data_out holds a completed sum
//   data_out   out  OUT_W   group sum (registered)
//
// Configuration macro:
//   ACCU_ZERO_IDLE_EN  defined   : data_out is cleared (registered) whenever
//                                  valid_out is low.
//                      undefined : data_out holds the last group sum between
//                                  pulses.
module accu_sum4 #(
  parameter int DATA_W    = 8,
  parameter int NUM_ITEMS = 4,
  parameter int OUT_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              valid_out,
  output logic [OUT_W-1:0]  data_out
);

  // NUM_ITEMS >= 2, so $clog2 is always at least 1.
  localparam int CNT_W = $clog2(NUM_ITEMS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ITEMS - 1);

  logic [OUT_W-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_out_r;
  logic [OUT_W-1:0] data_out_r;

  logic [OUT_W-1:0] sum_s;
  logic             last_s;
  logic [OUT_W-1:0] acc_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic [OUT_W-1:0] data_out_next_s;

  // Next-state computation for the accumulator, sample counter and outputs.
  always_comb begin
    sum_s           = acc_r + OUT_W'(data_in);
    last_s          = 1'b0;
    acc_next_s      = acc_r;
    count_next_s    = count_r;
    data_out_next_s = data_out_r;

    if (valid_in) begin
      if (count_r == LAST_IDX) begin
        // Last sample of the group: publish the total, start a fresh group.
        last_s       = 1'b1;
        acc_next_s   = {OUT_W{1'b0}};
        count_next_s = {CNT_W{1'b0}};
      end else begin
        acc_next_s   = sum_s;
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      // Paused group: accumulator and counter keep their values.
      acc_next_s   = acc_r;
      count_next_s = count_r;
    end

    if (last_s) begin
      data_out_next_s = sum_s;
    end else begin
`ifdef ACCU_ZERO_IDLE_EN
      data_out_next_s = {OUT_W{1'b0}};
`else
      data_out_next_s = data_out_r;
`endif
    end
  end

  // State and output registers; reset discards any partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {OUT_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      valid_out_r <= 1'b0;
      data_out_r  <= {OUT_W{1'b0}};
    end else begin
      acc_r       <= acc_next_s;
      count_r     <= count_next_s;
      valid_out_r <= last_s;
      data_out_r  <= data_out_next_s;
    end
  end

  assign valid_out = valid_out_r;
  assign data_out  = data_out_r;

endmodule

// File: tb/tb_accu_sum4.sv
// tb_accu_sum4 - self-checking bench for accu_sum4.
//
// Inputs are driven just after the falling edge and outputs are sampled on
// the falling edge. A small reference model runs alongside the stimulus;
// every completed group pushes its expected sum onto a scoreboard queue that
// is popped whenever the DUT raises valid_out. Define ACCU_ZERO_IDLE_EN for
// both bench and RTL to exercise the zero-idle build.
module tb_accu_sum4;

  localparam int DATA_W    = 8;
  localparam int NUM_ITEMS = 4;
  localparam int OUT_W     = 10;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              valid_out;
  logic [OUT_W-1:0]  data_out;

  int n_checks;
  int n_fail;

  // Reference model state
  int          m_acc;
  int          m_cnt;
  logic        m_valid;
  int          m_data;
  int          sb_q[$];

  accu_sum4 #(
    .DATA_W   (DATA_W),
    .NUM_ITEMS(NUM_ITEMS),
    .OUT_W    (OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .valid_in (valid_in),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model at the rising edge, compare at
  // the following falling edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d);
    int sum;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    m_valid = 1'b0;
    if (v) begin
      if (m_cnt == NUM_ITEMS - 1) begin
        sum     = m_acc + int'(d);
        sb_q.push_back(sum);
        m_valid = 1'b1;
        m_data  = sum;
        m_acc   = 0;
        m_cnt   = 0;
      end else begin
        m_acc = m_acc + int'(d);
        m_cnt = m_cnt + 1;
      end
    end
`ifdef ACCU_ZERO_IDLE_EN
    if (!m_valid) m_data = 0;
`endif
    @(negedge clk);
    check_eq("valid_out", 32'(valid_out), 32'(m_valid));
    if (valid_out) begin
      if (sb_q.size() > 0) begin
        check_eq("sb_sum", 32'(data_out), 32'(sb_q.pop_front()));
      end else begin
        check_eq("sb_pending", 32'(sb_q.size()), 32'd1);
      end
    end
    check_eq("data_out", 32'(data_out), 32'(m_data));
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_data  = 0;
    sb_q.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] s2 [12];
    n_checks = 0;
    n_fail   = 0;
    s2 = '{8'd1, 8'd2, 8'd3, 8'd14, 8'd5, 8'd2, 8'd103, 8'd4,
           8'd5, 8'd6, 8'd3, 8'd54};

    // 1. Reset held for two cycles
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid_out", 32'(valid_out), 32'd0);
    check_eq("rst_data_out",  32'(data_out),  32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'd0);

    // 4. Max values, then zeros immediately after
    for (int i = 0; i < 4; i++) step(1'b1, 8'd255);
    check_eq("max_sum", 32'(data_out), 32'd1020);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd0);
    check_eq("zero_sum_valid", 32'(valid_out), 32'd1);
    step(1'b0, 8'd0);

    // 2 / 6. Back-to-back groups with valid_in held high
    for (int i = 0; i < 12; i++) begin
      step(1'b1, s2[i]);
      if (i == 3)  check_eq("grp1_sum", 32'(data_out), 32'd20);
      if (i == 7)  check_eq("grp2_sum", 32'(data_out), 32'd114);
      if (i == 11) check_eq("grp3_sum", 32'(data_out), 32'd68);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0);

    // 3. Gapped input
    step(1'b1, 8'd10);
    step(1'b0, 8'd0);
    step(1'b1, 8'd20);
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    step(1'b1, 8'd30);
    step(1'b1, 8'd40);
    check_eq("gap_sum", 32'(data_out), 32'd100);
    step(1'b0, 8'd0);

    // 5. Reset mid-group, asserted asynchronously between edges
    step(1'b1, 8'd7);
    step(1'b1, 8'd7);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid_out", 32'(valid_out), 32'd0);
    check_eq("async_data_out",  32'(data_out),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1);
    check_eq("post_rst_sum", 32'(data_out), 32'd4);
    for (int i = 0; i < 2; i++) step(1'b0, 8'd0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
